// File: rtl/line_word_adapter.sv
// Bridges a 128-bit cache line port onto a 16-bit word memory by running
// an 8-word burst per line fill or evict, then pulsing pmem_resp once.
module line_word_adapter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic [15:0]  mem_address,
    output logic         mem_read,
    output logic         mem_write,
    output logic [15:0]  mem_wdata,
    input  logic [15:0]  mem_rdata,
    input  logic         mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        RESP
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         accept;
    logic         in_burst;
    logic [2:0]   cnt;
    logic [11:0]  line_addr;
    logic [127:0] wdata_q;
    logic [127:0] rdata_q;
    logic [6:0]   word_lsb;
    logic         unused_addr_bits;

    // The word offset inside the line is implied by the burst counter.
    assign unused_addr_bits = &{1'b0, pmem_address[3:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (pmem_write) begin
                    state_next = WR_BURST;
                    accept     = 1'b1;
                end else if (pmem_read) begin
                    state_next = RD_BURST;
                    accept     = 1'b1;
                end
            end
            RD_BURST, WR_BURST: begin
                if (mem_resp && (cnt == 3'd7)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_burst = (state == RD_BURST) || (state == WR_BURST);
    assign word_lsb = {cnt, 4'b0000};

    // Request fields are captured once on accept; the cache side may change
    // or drop them freely while the burst is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 3'd0;
            line_addr <= 12'd0;
            wdata_q   <= 128'd0;
            rdata_q   <= 128'd0;
        end else if (accept) begin
            cnt       <= 3'd0;
            line_addr <= pmem_address[15:4];
            wdata_q   <= pmem_wdata;
        end else if (in_burst && mem_resp) begin
            cnt <= cnt + 3'd1;
            if (state == RD_BURST) begin
                rdata_q[word_lsb +: 16] <= mem_rdata;
            end
        end
    end

    assign pmem_rdata  = rdata_q;
    assign pmem_resp   = (state == RESP);
    assign mem_read    = (state == RD_BURST);
    assign mem_write   = (state == WR_BURST);
    assign mem_address = in_burst ? {line_addr, cnt, 1'b0} : 16'd0;
    assign mem_wdata   = (state == WR_BURST) ? wdata_q[word_lsb +: 16] : 16'd0;

endmodule

// File: tb/tb_line_word_adapter.sv
// Directed bench for line_word_adapter: a cycle-by-cycle word memory model
// answers the strobes while each scenario task checks its own results.
module tb_line_word_adapter;

    logic         clk;
    logic         rst_n;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;

    int errors = 0;
    int checks = 0;

    logic [15:0]  obs_addr  [0:15];
    logic [15:0]  obs_wdata [0:15];
    int           nwords;
    int           resp_cycle;
    int           rd_cyc;
    int           wr_cyc;
    int           stab_err;
    logic [127:0] last_read_line;

    line_word_adapter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at the negedge of the accept cycle (cycle 0). Plays the word
    // memory until pmem_resp is seen, recording what the DUT presented.
    task automatic run_burst(input int waits, input logic [15:0] rbase,
                             input int drop_word, input logic next_rd,
                             input logic next_wr);
        int          waitcnt;
        logic        in_wait;
        logic [15:0] prev_addr;
        logic [15:0] prev_wdata;
        logic        prev_rd;
        logic        prev_wr;
        nwords = 0; resp_cycle = -1; rd_cyc = 0; wr_cyc = 0; stab_err = 0;
        waitcnt = 0; in_wait = 1'b0;
        prev_addr = 16'd0; prev_wdata = 16'd0; prev_rd = 1'b0; prev_wr = 1'b0;
        for (int cyc = 1; cyc <= 200 && resp_cycle < 0; cyc++) begin
            @(negedge clk);
            if (pmem_resp) begin
                resp_cycle = cyc;
                mem_resp   = 1'b0;
                pmem_read  = next_rd;
                pmem_write = next_wr;
            end else if (mem_read || mem_write) begin
                if (mem_read)  rd_cyc++;
                if (mem_write) wr_cyc++;
                if (in_wait && (mem_address !== prev_addr || mem_wdata !== prev_wdata ||
                                mem_read !== prev_rd || mem_write !== prev_wr))
                    stab_err++;
                if (!in_wait && nwords == drop_word) pmem_read = 1'b0;
                prev_addr = mem_address; prev_wdata = mem_wdata;
                prev_rd = mem_read; prev_wr = mem_write;
                if (waitcnt < waits) begin
                    mem_resp = 1'b0;
                    waitcnt++;
                    in_wait = 1'b1;
                end else begin
                    mem_resp  = 1'b1;
                    mem_rdata = rbase + 16'(nwords);
                    if (nwords < 16) begin
                        obs_addr[nwords]  = mem_address;
                        obs_wdata[nwords] = mem_wdata;
                    end
                    nwords++;
                    waitcnt = 0;
                    in_wait = 1'b0;
                end
            end else begin
                mem_resp = 1'b0;
                in_wait  = 1'b0;
            end
        end
        mem_resp = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (pmem_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got resp=%b rd=%b wr=%b, want 0 0 0",
                     pmem_resp, mem_read, mem_write);
        end
        checks++;
        if (mem_address !== 16'd0 || mem_wdata !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_mem_bus: got addr=%h wdata=%h, want 0000 0000",
                     mem_address, mem_wdata);
        end
        checks++;
        if (pmem_rdata !== 128'd0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h, want 0", pmem_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pmem_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_no_request: got resp=%b rd=%b wr=%b, want 0 0 0",
                     pmem_resp, mem_read, mem_write);
        end
    endtask

    task automatic test_read_zero_wait();
        logic [127:0] exp_line;
        pmem_address = 16'h1234;
        pmem_read    = 1'b1;
        run_burst(0, 16'hA000, -1, 1'b0, 1'b0);
        checks++;
        if (resp_cycle != 9) begin
            errors++;
            $display("[TB] FAIL read_latency: got resp cycle %0d, want 9", resp_cycle);
        end
        checks++;
        if (nwords != 8 || rd_cyc != 8 || wr_cyc != 0) begin
            errors++;
            $display("[TB] FAIL read_word_count: got words=%0d rd=%0d wr=%0d, want 8 8 0",
                     nwords, rd_cyc, wr_cyc);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_addr[k] !== 16'h1230 + 16'(2 * k)) begin
                errors++;
                $display("[TB] FAIL read_addr[%0d]: got %h, want %h", k, obs_addr[k],
                         16'h1230 + 16'(2 * k));
            end
        end
        for (int k = 0; k < 8; k++) exp_line[16*k +: 16] = 16'hA000 + 16'(k);
        checks++;
        if (pmem_rdata !== exp_line) begin
            errors++;
            $display("[TB] FAIL read_line: got %h, want %h", pmem_rdata, exp_line);
        end
        last_read_line = exp_line;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pmem_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                errors++;
                $display("[TB] FAIL read_after_resp: got resp=%b rd=%b wr=%b, want 0 0 0",
                         pmem_resp, mem_read, mem_write);
            end
        end
    endtask

    task automatic test_write_waits();
        for (int k = 0; k < 8; k++) pmem_wdata[16*k +: 16] = 16'h0100 * 16'(k);
        pmem_address = 16'h5678;
        pmem_write   = 1'b1;
        run_burst(2, 16'hDEAD, -1, 1'b0, 1'b0);
        checks++;
        if (resp_cycle != 25) begin
            errors++;
            $display("[TB] FAIL write_latency: got resp cycle %0d, want 25", resp_cycle);
        end
        checks++;
        if (nwords != 8 || wr_cyc != 24 || rd_cyc != 0) begin
            errors++;
            $display("[TB] FAIL write_counts: got words=%0d wr=%0d rd=%0d, want 8 24 0",
                     nwords, wr_cyc, rd_cyc);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_wdata[k] !== 16'h0100 * 16'(k) || obs_addr[k] !== 16'h5670 + 16'(2 * k)) begin
                errors++;
                $display("[TB] FAIL write_word[%0d]: got addr=%h data=%h, want addr=%h data=%h",
                         k, obs_addr[k], obs_wdata[k], 16'h5670 + 16'(2 * k), 16'h0100 * 16'(k));
            end
        end
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("[TB] FAIL write_stable: got %0d unstable wait cycles, want 0", stab_err);
        end
        checks++;
        if (pmem_rdata !== last_read_line) begin
            errors++;
            $display("[TB] FAIL write_keeps_rdata: got %h, want %h", pmem_rdata, last_read_line);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) pmem_wdata[16*k +: 16] = 16'h7700 + 16'(k);
        pmem_address = 16'h2000;
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        run_burst(0, 16'hBAD0, -1, 1'b1, 1'b0);
        checks++;
        if (wr_cyc != 8 || rd_cyc != 0 || resp_cycle != 9) begin
            errors++;
            $display("[TB] FAIL priority_write: got wr=%0d rd=%0d resp=%0d, want 8 0 9",
                     wr_cyc, rd_cyc, resp_cycle);
        end
        checks++;
        if (obs_wdata[7] !== 16'h7707 || obs_addr[7] !== 16'h200E) begin
            errors++;
            $display("[TB] FAIL priority_last_word: got addr=%h data=%h, want 200e 7707",
                     obs_addr[7], obs_wdata[7]);
        end
        pmem_address = 16'h3000;
        @(negedge clk);
        checks++;
        if (pmem_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle_cycle: got resp=%b rd=%b wr=%b, want 0 0 0",
                     pmem_resp, mem_read, mem_write);
        end
        run_burst(0, 16'h3300, -1, 1'b0, 1'b0);
        checks++;
        if (resp_cycle != 9 || rd_cyc != 8 || obs_addr[0] !== 16'h3000) begin
            errors++;
            $display("[TB] FAIL b2b_read: got resp=%0d rd=%0d addr0=%h, want 9 8 3000",
                     resp_cycle, rd_cyc, obs_addr[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        logic         found;
        logic [127:0] exp_line;
        found        = 1'b0;
        pmem_address = 16'h0800;
        pmem_read    = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            mem_resp  = 1'b1;
            mem_rdata = 16'hBEEF;
            if (mem_read && mem_address == 16'h0808) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL reset_reach_word4: got no word 4 strobe, want addr 0808");
        end
        mem_resp = 1'b0;
        #2;
        rst_n     = 1'b0;
        pmem_read = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_address !== 16'd0 || pmem_resp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_abort: got rd=%b addr=%h resp=%b, want 0 0000 0",
                     mem_read, mem_address, pmem_resp);
        end
        checks++;
        if (pmem_rdata !== 128'd0) begin
            errors++;
            $display("[TB] FAIL async_rdata_clear: got %h, want 0", pmem_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (pmem_resp !== 1'b0 || mem_read !== 1'b0) begin
                errors++;
                $display("[TB] FAIL no_resp_after_abort: got resp=%b rd=%b, want 0 0",
                         pmem_resp, mem_read);
            end
        end
        pmem_address = 16'h0040;
        pmem_read    = 1'b1;
        run_burst(0, 16'hC000, -1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_addr[k] !== 16'h0040 + 16'(2 * k)) begin
                errors++;
                $display("[TB] FAIL fresh_addr[%0d]: got %h, want %h", k, obs_addr[k],
                         16'h0040 + 16'(2 * k));
            end
        end
        for (int k = 0; k < 8; k++) exp_line[16*k +: 16] = 16'hC000 + 16'(k);
        checks++;
        if (resp_cycle != 9 || pmem_rdata !== exp_line) begin
            errors++;
            $display("[TB] FAIL fresh_read: got resp=%0d line=%h, want 9 %h",
                     resp_cycle, pmem_rdata, exp_line);
        end
        last_read_line = exp_line;
        @(negedge clk);
    endtask

    task automatic test_drop_request();
        pmem_address = 16'h4440;
        pmem_read    = 1'b1;
        run_burst(1, 16'h9000, 2, 1'b0, 1'b0);
        checks++;
        if (nwords != 8 || resp_cycle != 17) begin
            errors++;
            $display("[TB] FAIL drop_completes: got words=%0d resp=%0d, want 8 17",
                     nwords, resp_cycle);
        end
        checks++;
        if (pmem_rdata[127:112] !== 16'h9007 || pmem_rdata[15:0] !== 16'h9000) begin
            errors++;
            $display("[TB] FAIL drop_rdata: got %h, want word7=9007 word0=9000", pmem_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (pmem_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                errors++;
                $display("[TB] FAIL drop_idle: got resp=%b rd=%b wr=%b, want 0 0 0",
                         pmem_resp, mem_read, mem_write);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        pmem_address   = 16'd0;
        pmem_wdata     = 128'd0;
        mem_rdata      = 16'd0;
        mem_resp       = 1'b0;
        last_read_line = 128'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_back_to_back();
        test_reset_mid_burst();
        test_drop_request();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_word_adapter.md
LINE_WORD_ADAPTER -- requirements
Module: line_word_adapter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  Clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  Asynchronous active-low reset.
REQ-004 pmem_read  input  1  Cache line-fill request; held high until pmem_resp.
REQ-005 pmem_write  input  1  Cache line-evict request; held high until pmem_resp.
REQ-006 pmem_address  input  16  Line address; bits [3:0] are ignored.
REQ-007 pmem_wdata  input  128  Line to write; word k is bits [16k+15:16k].
REQ-008 pmem_rdata  output  128  Filled line, in the same word order.
REQ-009 pmem_resp  output  1  Single-cycle completion strobe to the cache.
REQ-010 mem_address  output  16  Word address to the word-wide memory.
REQ-011 mem_read / mem_write  output  1 each  Word strobes, held until mem_resp.
REQ-012 mem_wdata  output  16  Word to write.
REQ-013 mem_rdata  input  16  Word read data, valid in any cycle where mem_resp=1.
REQ-014 mem_resp  input  1  Word handshake complete; may arrive in the first strobe cycle.

Function
REQ-015 The FSM SHALL have the states IDLE, RD_BURST, WR_BURST and RESP.
REQ-016 IDLE: on pmem_write=1 the FSM SHALL go to WR_BURST; else on pmem_read=1 it SHALL go to RD_BURST; else it SHALL stay in IDLE.
REQ-017 When both requests are high, the write SHALL take priority and the read SHALL be ignored.
REQ-018 On leaving IDLE, the module SHALL latch pmem_address[15:4] and pmem_wdata.
REQ-019 On leaving IDLE, the 3-bit word counter SHALL be cleared to 0.
REQ-020 In a burst, mem_address SHALL be {line[15:4], cnt, 1'b0}.
REQ-021 In RD_BURST, mem_read SHALL be 1.
REQ-022 In WR_BURST, mem_write SHALL be 1 and mem_wdata SHALL be latched word cnt.
REQ-023 In any other state, mem_read and mem_write SHALL be 0.
REQ-024 For each mem_resp=1 in RD_BURST, mem_rdata SHALL be captured into pmem_rdata word cnt.
REQ-025 For each mem_resp=1 in either burst state, cnt SHALL increment.
REQ-026 When mem_resp=1 and cnt=7, the FSM SHALL go to RESP; cnt SHALL wrap to 0 and SHALL NOT be reused.
REQ-027 Exactly 8 word transfers SHALL occur per line, in order 0..7.
REQ-028 While mem_resp=0, the strobes, address and data SHALL remain stable.
REQ-029 RESP SHALL assert pmem_resp=1 for exactly one cycle, then the FSM SHALL go to IDLE unconditionally.
REQ-030 IDLE SHALL evaluate requests in the cycle after RESP, so back-to-back write-then-read works without a gap.
REQ-031 pmem_rdata SHALL hold its value until overwritten by the next read burst.
REQ-032 Words written by a write burst SHALL NOT alter pmem_rdata.
REQ-033 The pmem_* inputs SHALL be ignored outside IDLE; a request dropped mid-burst SHALL still complete the burst and pulse pmem_resp.
REQ-034 With zero-wait memory (mem_resp=1 in every strobe cycle), pmem_resp SHALL be asserted in cycle 9 after the IDLE accept cycle (cycle 0).
REQ-035 Each memory wait cycle SHALL add exactly 1 cycle to that latency.

Reset
REQ-036 On rst_n=0, the FSM SHALL enter IDLE immediately, regardless of clk.
REQ-037 On rst_n=0, cnt, the latched line address, the latched wdata and pmem_rdata SHALL be cleared to 0.
REQ-038 On rst_n=0, pmem_resp, mem_read and mem_write SHALL be 0; mem_address and mem_wdata SHALL be 0.
REQ-039 Reset mid-burst SHALL abort the burst with no pmem_resp; the first request seen after rst_n rises SHALL start a fresh burst at word 0.

Verification
REQ-040 Zero-wait read, pmem_address=0x1234, memory returns word k = 0xA000+k -> mem_address steps 0x1230, 0x1232 ... 0x123E; pmem_rdata=0xA007_A006_..._A000; pmem_resp pulses once at cycle 9.
REQ-041 Write with pmem_wdata word k = 0x0100*k, memory inserts 2 wait cycles on every word -> mem_wdata sequence 0x0000 ... 0x0700; pmem_resp at cycle 25; pmem_rdata unchanged.
REQ-042 pmem_read=pmem_write=1 together -> only mem_write is issued for 8 words and one pmem_resp follows; a subsequent read held high starts in the cycle after RESP.
REQ-043 rst_n pulsed low during word 4 of a read -> strobes drop asynchronously and no pmem_resp occurs; a new read at 0x0040 then transfers addresses 0x0040..0x004E from word 0.
REQ-044 pmem_read deasserted during word 2 -> the burst completes all 8 words, pmem_resp pulses once, then the FSM stays in IDLE with no strobes.
